// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: req/ack data-memory bus, pipeline stall, load extension.
// Optional bus timeout enabled by defining MEM_TIMEOUT_EN (TIMEOUT_CYCLES sets the limit).
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd_M,
  input  logic        mem_wr_M,
  input  logic [2:0]  funct3_M,
  input  logic [31:0] alu_o_M,
  input  logic [31:0] wr_data_M,
  output logic [31:0] rd_data_M,
  output logic        stall_mem,
  output logic        mem_fault_M,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic        op;
  logic        illegal;
  logic        misaligned;
  logic        fault;
  logic        start;
  logic [1:0]  lane;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [31:0] shifted;
  logic [31:0] load_ext;
  logic        ack_valid;
  logic        expire;

  assign op        = mem_rd_M | mem_wr_M;
  assign lane      = alu_o_M[1:0];
  assign ack_valid = dmem_ack & dmem_req;

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (mem_rd_M && mem_wr_M) begin
      illegal = 1'b1;
    end else if (mem_rd_M) begin
      illegal = !(funct3_M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end else if (mem_wr_M) begin
      illegal = !(funct3_M inside {3'b000, 3'b001, 3'b010});
    end
    if (funct3_M[1:0] == 2'b01) misaligned = lane[0];
    if (funct3_M[1:0] == 2'b10) misaligned = (lane != 2'b00);
  end

  assign fault       = op & (illegal | misaligned);
  assign start       = (state == IDLE) & op & ~fault;
  assign mem_fault_M = ~rst & (state == IDLE) & fault;
  assign stall_mem   = ~rst & (start | (state == REQ));

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wr_data_M;
    case (funct3_M[1:0])
      2'b00: begin
        be_next    = 4'b0001 << lane;
        wdata_next = {4{wr_data_M[7:0]}};
      end
      2'b01: begin
        be_next    = lane[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{wr_data_M[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted  = dmem_rdata >> {lane_q, 3'b000};
    load_ext = '0;
    case (f3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = shifted;
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = '0;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt;
  logic       bus_err_q;
  assign expire  = (to_cnt == TO_LAST);
  assign bus_err = bus_err_q;
`else
  // Parameter stays referenced so the untimed build keeps the same interface.
  assign expire  = 1'b0 & (TIMEOUT_CYCLES == 0);
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      rd_data_M  <= '0;
      f3_q       <= '0;
      lane_q     <= '0;
`ifdef MEM_TIMEOUT_EN
      to_cnt     <= '0;
      bus_err_q  <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      bus_err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          rd_data_M <= '0;
          if (start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_wr_M;
            dmem_addr  <= {alu_o_M[31:2], 2'b00};
            dmem_be    <= be_next;
            dmem_wdata <= wdata_next;
            f3_q       <= funct3_M;
            lane_q     <= lane;
`ifdef MEM_TIMEOUT_EN
            to_cnt     <= '0;
`endif
            state      <= REQ;
          end
        end
        REQ: begin
`ifdef MEM_TIMEOUT_EN
          to_cnt <= to_cnt + 8'd1;
`endif
          // An ack arriving on the limit cycle completes normally.
          if (ack_valid) begin
            dmem_req  <= 1'b0;
            rd_data_M <= dmem_we ? '0 : load_ext;
            state     <= DONE;
          end else if (expire) begin
            dmem_req  <= 1'b0;
            rd_data_M <= '0;
`ifdef MEM_TIMEOUT_EN
            bus_err_q <= 1'b1;
`endif
            state     <= DONE;
          end
        end
        DONE: begin
          rd_data_M <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
